// File: rtl/dmem_responder.sv
// Data-memory responder: a valid/ready load/store port backed by a word array, with a fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses; otherwise they are silently aligned.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_nextState;
  logic [3:0]    r_count, w_nextCount;
  logic          r_armed;
  logic          r_we, r_unsigned;
  logic [31:0]   r_addr, r_wdata;
  logic [1:0]    r_size;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept, w_commit, w_err;
  logic          w_opWe, w_opUnsigned;
  logic [31:0]   w_opAddr, w_opWdata;
  logic [1:0]    w_opSize, w_lane;
  logic [AW-1:0] w_index;
  logic [31:0]   w_word, w_loadData, w_storeWord;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [3:0]    w_byteEn;

  // r_armed holds off req_ready until the first edge after reset releases
  assign req_ready = r_armed && (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_accept  = req_valid && req_ready;
  assign w_commit  = ((r_state == S_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                     ((r_state == S_WAIT) && (r_count == 4'd0));

  // With zero wait cycles the commit happens on the accepting edge, so the live request is used
  assign w_opWe       = (r_state == S_IDLE) ? req_we       : r_we;
  assign w_opUnsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;
  assign w_opAddr     = (r_state == S_IDLE) ? req_addr     : r_addr;
  assign w_opWdata    = (r_state == S_IDLE) ? req_wdata    : r_wdata;
  assign w_opSize     = (r_state == S_IDLE) ? req_size     : r_size;
  assign w_index      = w_opAddr[AW+1:2];
  assign w_word       = r_mem[w_index];

  always_comb begin
    w_err       = (w_opSize == 2'b11) || ({1'b0, w_opAddr} >= BYTE_LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
    w_err       = w_err || ((w_opSize == 2'b01) && w_opAddr[0]) ||
                  ((w_opSize == 2'b10) && (w_opAddr[1:0] != 2'b00));
`endif
    w_lane      = 2'b00;
    w_byteEn    = 4'b0000;
    w_storeWord = w_opWdata;
    case (w_opSize)
      2'b00: begin
        w_lane      = w_opAddr[1:0];
        w_byteEn    = 4'b0001 << w_lane;
        w_storeWord = {4{w_opWdata[7:0]}};
      end
      2'b01: begin
        w_lane      = {w_opAddr[1], 1'b0};
        w_byteEn    = 4'b0011 << w_lane;
        w_storeWord = {2{w_opWdata[15:0]}};
      end
      2'b10:   w_byteEn = 4'b1111;
      default: w_byteEn = 4'b0000;
    endcase
    w_byte = w_word[{w_lane, 3'b000} +: 8];
    w_half = w_word[{w_lane[1], 4'b0000} +: 16];
    case (w_opSize)
      2'b00:   w_loadData = w_opUnsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_loadData = w_opUnsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loadData = w_word;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_nextState = S_RESP;
          end else begin
            w_nextState = S_WAIT;
            w_nextCount = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_count == 4'd0) w_nextState = S_RESP;
        else                 w_nextCount = r_count - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_armed    <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_armed <= 1'b1;
      if (w_accept) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_opWe) ? 32'd0 : w_loadData;
      end
    end
  end

  // Backing store is deliberately left out of reset so contents survive it
  always_ff @(posedge clk) begin
    if (w_commit && w_opWe && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) r_mem[w_index][8*b +: 8] <= w_storeWord[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [7:0]  refMem [BYTES];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Little-endian byte memory; access width and alignment derived directly from the size code
  function automatic void refModel(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [1:0] size, input logic uns,
                                   output logic err, output logic [31:0] data);
    int          nBytes;
    logic [31:0] ea, val;
    err  = (size == 2'b11) || (addr >= 32'(BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size == 2'b01 && addr[0]) err = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    data = 32'd0;
    if (err) return;
    nBytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    ea     = addr & ~(32'(nBytes) - 32'd1);
    if (we) begin
      for (int i = 0; i < nBytes; i++) refMem[ea + 32'(i)] = 8'((wdata >> (8*i)) & 32'hFF);
    end else begin
      val = 32'd0;
      for (int i = 0; i < nBytes; i++) val |= 32'(refMem[ea + 32'(i)]) << (8*i);
      if (nBytes < 4 && !uns && val[8*nBytes-1]) val |= ~((32'd1 << (8*nBytes)) - 32'd1);
      data = val;
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns, input int holdCycles,
                               input string tag, output logic [31:0] obsData);
    logic        expErr;
    logic [31:0] expData, held;
    int          lat;
    bit          sawReady, stable;
    refModel(we, addr, wdata, size, uns, expErr, expData);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; rsp_ready = 1'b0;
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble the request bus to show it is ignored once the request is taken
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 0; sawReady = 0;
    do begin
      @(negedge clk); lat++;
      if (req_ready) sawReady = 1;
    end while (!rsp_valid && lat < 40);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
    checkOutput({tag, "_busy_ready"}, 32'(sawReady), 32'd0);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
    checkOutput({tag, "_rdata"}, rsp_rdata, expData);
    held = rsp_rdata; stable = 1;
    repeat (holdCycles) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held || req_ready) stable = 0;
    end
    checkOutput({tag, "_hold"}, 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_handoff_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_handoff_ready"}, 32'(req_ready), 32'd1);
    obsData = held;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          noResp;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(req_ready), 32'd1);

    // Fill the low window so every later load compares against known data
    for (int w = 0; w < 32; w++) applyStimulus(1'b1, 32'(w*4), $urandom, 2'b10, 1'b0, 0, "init", d);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, "st_word", d);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "ld_word", d);
    checkOutput("ld_word_const", d, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, "ld_byte_s", d);
    checkOutput("ld_byte_s_const", d, 32'hFFFFFFDE);
    applyStimulus(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, "ld_byte_u", d);
    checkOutput("ld_byte_u_const", d, 32'h000000DE);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 0, "ld_half_s", d);
    checkOutput("ld_half_s_const", d, 32'hFFFFBEEF);
    applyStimulus(1'b1, 32'h11, 32'h55, 2'b00, 1'b0, 0, "st_byte", d);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, "ld_merged", d);
    checkOutput("ld_merged_const", d, 32'hDEAD55EF);
    applyStimulus(1'b0, 32'(BYTES), 32'h0, 2'b10, 1'b0, 0, "ld_oob", d);
    applyStimulus(1'b0, 32'h11, 32'h0, 2'b01, 1'b1, 0, "ld_half_mis", d);
    applyStimulus(1'b1, 32'h14, 32'hA5A5A5A5, 2'b11, 1'b0, 0, "st_illegal", d);
    applyStimulus(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, "ld_after_illegal", d);
    applyStimulus(1'b1, 32'h1A, 32'hCAFEF00D, 2'b10, 1'b0, 0, "st_word_mis", d);
    applyStimulus(1'b0, 32'h18, 32'h0, 2'b10, 1'b0, 0, "ld_after_mis", d);

    // Reset lands in the last wait cycle, just before the store would commit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    noResp = 1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) noResp = 0;
    end
    checkOutput("rst_mid_no_resp", 32'(noResp), 32'd1);
    applyStimulus(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, "ld_after_rst", d);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'(BYTES) + 32'($urandom_range(0, 255))
                                      : 32'($urandom_range(0, 127));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand", d);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, backing-store depth in 32-bit words (power of two).
REQ-002 Parameter: WAIT_CYCLES, default 2, added cycles between request accept and response (0..15).
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  1  initiator presents a load/store request.
REQ-006 Port: req_ready  output  1  responder accepts the request this cycle.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 Port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  initiator takes the response.
REQ-014 Port: rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 Port: rsp_err  output  1  request faulted; no store performed.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on req_valid&&req_ready, capture we/addr/wdata/size/unsigned; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-018 WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; go to RESP on the edge where counter is 0.
REQ-019 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 Array read and store commit SHALL occur on the edge entering RESP; rsp_rdata/rsp_err registered there and held stable while rsp_valid=1.
REQ-021 RESP: rsp_valid held until rsp_valid&&rsp_ready; then IDLE; no new request accepted in the same cycle as response handoff.
REQ-022 Store lanes: byte writes lane addr[1:0], half writes lanes addr[1]*2..+1, word writes all; other lanes unchanged.
REQ-023 Load: lane selected by addr[1:0]; byte/half extended to 32 bits per req_unsigned; word passed through.
REQ-024 Error (rsp_err=1, no store, rsp_rdata=0) for req_size=11 or req_addr >= DEPTH_WORDS*4.
REQ-025 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; no wrap-around for out-of-range addresses (REQ-024 applies).
REQ-026 Inputs other than rsp_ready ignored outside IDLE; req_* changes during WAIT/RESP have no effect.

Reset
REQ-027 While rst=1: state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from first edge after rst deasserts.
REQ-028 Reset mid-transaction drops it; a store not yet committed (state WAIT) SHALL NOT be written.
REQ-029 Backing-store contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> rsp_err=1, rsp_rdata=0, no store.
REQ-031 Macro undefined: misaligned addresses silently aligned (half clears addr[0], word clears addr[1:0]); rsp_err=0.

Verification
REQ-032 WAIT_CYCLES=2: word store 0xDEADBEEF @0x10 accepted cycle 0 -> rsp_valid cycle 3, rsp_err=0; word load @0x10 -> rsp_rdata=0xDEADBEEF.
REQ-033 After REQ-032: byte load @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half load @0x10 signed -> 0xFFFFBEEF.
REQ-034 Byte store 0x55 @0x11 then word load @0x10 -> 0xDEAD55EF.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; handoff -> req_ready=1 next cycle.
REQ-036 Load @DEPTH_WORDS*4 -> rsp_err=1, rdata 0; half load @0x11: macro defined -> rsp_err=1; undefined -> rsp_err=0, rdata from 0x10.
REQ-037 Word store 0x12345678 @0x20, rst pulsed in WAIT -> no response; subsequent load @0x20 returns prior contents.
